// File: rtl/wt_inval_queue.sv
// wt_inval_queue: buffers snoop invalidations for the write-through D$.
// Incoming byte addresses are line-aligned, checked against every pending
// entry (duplicates are merged and counted), and the rest are queued in
// FIFO order. The head is offered on a valid/ready invalidation port.
// Every output is decoded from registered state only.
module wt_inval_queue #(
    parameter int Depth           = 4,
    parameter int AddrWidth       = 64,
    parameter int LineOffsetWidth = 4,
    parameter int CntWidth        = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 snoop_valid_i,
    input  logic [AddrWidth-1:0] snoop_addr_i,
    output logic                 snoop_ready_o,
    output logic                 inval_valid_o,
    output logic [AddrWidth-1:0] inval_addr_o,
    input  logic                 inval_ready_i,
    output logic                 empty_o,
    output logic [CntWidth-1:0]  merge_cnt_o
);

    localparam int PtrW = $clog2(Depth);
    localparam logic [AddrWidth-1:0] LineMask =
        ~((AddrWidth'(1) << LineOffsetWidth) - AddrWidth'(1));
    localparam logic [PtrW:0] FullCount = (PtrW+1)'(Depth);

    logic [AddrWidth-1:0] r_mem [Depth];
    logic [Depth-1:0]     r_vld;
    logic [PtrW-1:0]      r_rd_ptr;
    logic [PtrW-1:0]      r_wr_ptr;
    logic [PtrW:0]        r_count;
    logic [CntWidth-1:0]  r_merge_cnt;

    logic [AddrWidth-1:0] w_line;
    logic [Depth-1:0]     w_hit;
    logic                 w_pop;
    logic                 w_accept;
    logic                 w_match;
    logic                 w_merge;
    logic                 w_enq;

    // Saturating increment for the merge statistics counter.
    function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
        if (&v) begin
            return v;
        end
        return v + CntWidth'(1);
    endfunction

    assign snoop_ready_o = (r_count != FullCount);
    assign inval_valid_o = (r_count != '0);
    assign empty_o       = (r_count == '0);
    assign inval_addr_o  = r_mem[r_rd_ptr];
    assign merge_cnt_o   = r_merge_cnt;

    assign w_line   = snoop_addr_i & LineMask;
    assign w_pop    = inval_valid_o & inval_ready_i;
    assign w_accept = snoop_valid_i & snoop_ready_o;

    // Compare the incoming line against every live entry; a head that is
    // leaving this cycle cannot absorb the snoop, since the cache may
    // already have processed it.
    always_comb begin
        w_hit = '0;
        for (int i = 0; i < Depth; i++) begin
            w_hit[i] = r_vld[i] && (r_mem[i] == w_line)
                       && !(w_pop && (PtrW'(i) == r_rd_ptr));
        end
    end

    assign w_match = |w_hit;
    assign w_merge = w_accept & w_match;
    assign w_enq   = w_accept & ~w_match;

    // Entry storage: data only, no reset needed.
    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_mem[r_wr_ptr] <= w_line;
        end
    end

    // Per-entry live bits, pointers and occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_vld    <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_pop) begin
                r_vld[r_rd_ptr] <= 1'b0;
                r_rd_ptr        <= r_rd_ptr + PtrW'(1);
            end
            if (w_enq) begin
                r_vld[r_wr_ptr] <= 1'b1;
                r_wr_ptr        <= r_wr_ptr + PtrW'(1);
            end
            case ({w_enq, w_pop})
                2'b10:   r_count <= r_count + (PtrW+1)'(1);
                2'b01:   r_count <= r_count - (PtrW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Count of snoops absorbed by an already-pending entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_merge_cnt <= '0;
        end else if (w_merge) begin
            r_merge_cnt <= sat_inc(r_merge_cnt);
        end
    end

endmodule

// File: tb/tb_wt_inval_queue.sv
// Directed bench for wt_inval_queue: reset, fill/backpressure, merge,
// head-pop race, wrap-around and asynchronous reset mid-operation.
module tb_wt_inval_queue;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        snoop_valid_i = 1'b0;
    logic [63:0] snoop_addr_i = '0;
    logic        snoop_ready_o;
    logic        inval_valid_o;
    logic [63:0] inval_addr_o;
    logic        inval_ready_i = 1'b0;
    logic        empty_o;
    logic [15:0] merge_cnt_o;

    int n_vec = 0;
    int n_err = 0;

    wt_inval_queue #(
        .Depth(4), .AddrWidth(64), .LineOffsetWidth(4), .CntWidth(16)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .snoop_valid_i (snoop_valid_i),
        .snoop_addr_i  (snoop_addr_i),
        .snoop_ready_o (snoop_ready_o),
        .inval_valid_o (inval_valid_o),
        .inval_addr_o  (inval_addr_o),
        .inval_ready_i (inval_ready_i),
        .empty_o       (empty_o),
        .merge_cnt_o   (merge_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_valid", 64'(inval_valid_o), 64'd0);
        check("rst_empty", 64'(empty_o), 64'd1);
        check("rst_ready", 64'(snoop_ready_o), 64'd1);
        check("rst_merge", 64'(merge_cnt_o), 64'd0);
        rst_ni = 1'b1;
        tick();

        // 1: single snoop, line alignment, pop
        snoop_valid_i = 1'b1; snoop_addr_i = 64'h8000_1234;
        tick();
        snoop_valid_i = 1'b0;
        check("t1_valid", 64'(inval_valid_o), 64'd1);
        check("t1_addr", inval_addr_o, 64'h8000_1230);
        check("t1_empty", 64'(empty_o), 64'd0);
        inval_ready_i = 1'b1;
        tick();
        inval_ready_i = 1'b0;
        check("t1_valid_after_pop", 64'(inval_valid_o), 64'd0);
        check("t1_empty_after_pop", 64'(empty_o), 64'd1);

        // 2: fill, backpressure, one-bubble refill, ordered drain
        snoop_valid_i = 1'b1;
        snoop_addr_i = 64'h100; tick();
        snoop_addr_i = 64'h200; tick();
        snoop_addr_i = 64'h300; tick();
        snoop_addr_i = 64'h400; tick();
        check("t2_full_ready", 64'(snoop_ready_o), 64'd0);
        snoop_addr_i = 64'h500; tick();
        check("t2_held_ready", 64'(snoop_ready_o), 64'd0);
        check("t2_head", inval_addr_o, 64'h100);
        inval_ready_i = 1'b1;
        tick();
        inval_ready_i = 1'b0;
        check("t2_ready_after_pop", 64'(snoop_ready_o), 64'd1);
        check("t2_head2", inval_addr_o, 64'h200);
        tick();
        snoop_valid_i = 1'b0;
        check("t2_refull", 64'(snoop_ready_o), 64'd0);
        inval_ready_i = 1'b1;
        check("t2_pop_a", inval_addr_o, 64'h200); tick();
        check("t2_pop_b", inval_addr_o, 64'h300); tick();
        check("t2_pop_c", inval_addr_o, 64'h400); tick();
        check("t2_pop_d", inval_addr_o, 64'h500); tick();
        inval_ready_i = 1'b0;
        check("t2_drained", 64'(empty_o), 64'd1);

        // 3: dedup of two snoops to the same line
        snoop_valid_i = 1'b1;
        snoop_addr_i = 64'h1000; tick();
        snoop_addr_i = 64'h1008; tick();
        snoop_addr_i = 64'h100C; tick();
        snoop_valid_i = 1'b0;
        check("t3_merge", 64'(merge_cnt_o), 64'd2);
        check("t3_head", inval_addr_o, 64'h1000);
        check("t3_ready", 64'(snoop_ready_o), 64'd1);
        inval_ready_i = 1'b1;
        tick();
        inval_ready_i = 1'b0;
        check("t3_single_entry", 64'(empty_o), 64'd1);

        // 4: snoop matching the head that is popping the same cycle
        snoop_valid_i = 1'b1; snoop_addr_i = 64'h2000;
        tick();
        snoop_addr_i = 64'h2004; inval_ready_i = 1'b1;
        tick();
        snoop_valid_i = 1'b0; inval_ready_i = 1'b0;
        check("t4_valid", 64'(inval_valid_o), 64'd1);
        check("t4_addr", inval_addr_o, 64'h2000);
        check("t4_merge", 64'(merge_cnt_o), 64'd2);
        inval_ready_i = 1'b1;
        tick();
        inval_ready_i = 1'b0;
        check("t4_count1", 64'(empty_o), 64'd1);

        // 5: wrap-around at full throughput
        inval_ready_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            snoop_valid_i = 1'b1; snoop_addr_i = 64'(k) * 64'h40;
            tick();
            check("t5_head", inval_addr_o, 64'(k) * 64'h40);
            check("t5_ready", 64'(snoop_ready_o), 64'd1);
        end
        snoop_valid_i = 1'b0;
        tick();
        inval_ready_i = 1'b0;
        check("t5_empty", 64'(empty_o), 64'd1);

        // 6: asynchronous reset with entries pending
        snoop_valid_i = 1'b1;
        snoop_addr_i = 64'h5000; tick();
        snoop_addr_i = 64'h5040; tick();
        snoop_addr_i = 64'h5080; tick();
        snoop_addr_i = 64'h5044; tick();
        snoop_valid_i = 1'b0;
        check("t6_pre_merge", 64'(merge_cnt_o), 64'd3);
        #2;
        rst_ni = 1'b0;
        #1;
        check("t6_valid", 64'(inval_valid_o), 64'd0);
        check("t6_empty", 64'(empty_o), 64'd1);
        check("t6_merge", 64'(merge_cnt_o), 64'd0);
        #10;
        rst_ni = 1'b1;
        snoop_valid_i = 1'b1; snoop_addr_i = 64'h3000;
        tick();
        snoop_valid_i = 1'b0;
        check("t6_head", inval_addr_o, 64'h3000);
        inval_ready_i = 1'b1;
        tick();
        inval_ready_i = 1'b0;
        check("t6_alone", 64'(empty_o), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
